// File: rtl/pc_fetch_unit.sv
// Program-counter owner and instruction fetch front end: fetches from imem, hands the word to decode, then steps the PC.
// Optional PC_ALIGN_CHECK_EN adds a misalign output and redirects misaligned targets to RESET_PC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  next_pc_sel,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_target,
    input  logic [31:0] crs,
    output logic [31:0] pc,
    output logic        fetch_err
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_en_q, req_en_d;
    logic          fetch_err_c;
    logic          misalign_q, misalign_d;

    logic [31:0] pc_inc, pc_equal, pc_jump, br_off, target;

    always_comb begin
        pc_inc   = pc_q + 32'd4;
        br_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};
        pc_equal = pc_inc + br_off;
        pc_jump  = {pc_inc[31:28], jump_target, 2'b00};
        case (next_pc_sel)
            2'b00:   target = pc_inc;
            2'b01:   target = pc_equal;
            2'b10:   target = pc_jump;
            default: target = crs;
        endcase
    end

    // req_en_q keeps imem_req low until the first edge after reset releases.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        cnt_d       = cnt_q;
        req_en_d    = 1'b1;
        fetch_err_c = 1'b0;
        misalign_d  = 1'b0;
        case (state_q)
            FETCH: begin
                if (req_en_q) begin
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ISSUE;
                    end else if (cnt_q == CNT_LAST) begin
                        fetch_err_c = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
`ifdef PC_ALIGN_CHECK_EN
                    if (target[1:0] != 2'b00) begin
                        pc_d       = RESET_PC;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = target;
                    end
`else
                    pc_d = target;
`endif
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            req_en_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            req_en_q   <= req_en_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req    = req_en_q && (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign fetch_err   = fetch_err_c;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign    = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program-counter register for the single-cycle processor.
- Generates the four next-PC candidates: pc_inc, pc_equal, pc_jump, crs.
- Applies the 2-bit next_pc_sel encoding used by the PC mux: 00 inc, 01 equal/branch, 10 jump, 11 crs.
- Runs the instruction-memory fetch handshake and hands each fetched instruction to decode with a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for imem_ack before flagging a fetch error and re-issuing the request.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  32  fetch address; always equals pc while imem_req is high.
- imem_ack  in  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  registered instruction presented to decode.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decode consumes instr; next_pc_sel and its operands are sampled in the same cycle.
- next_pc_sel  in  2  00 pc+4, 01 branch, 10 jump, 11 register (crs).
- branch_imm  in  16  signed word offset used for selection 01.
- jump_target  in  26  word index used for selection 10.
- crs  in  32  register value used for selection 11.
- pc  out  32  current PC.
- fetch_err  out  1  one-cycle pulse on fetch timeout.

Behaviour:
- Reset values (async, active-high):
  - pc=RESET_PC, state=FETCH, instr=0, instr_valid=0, fetch_err=0, timeout counter=0.
  - imem_req=0 while rst is high; imem_req=1 from the first clk edge after rst deasserts.
- Candidates (combinational from pc):
  - pc_inc = pc+4.
  - pc_equal = pc_inc + ({{14{branch_imm[15]}},branch_imm,2'b00}).
  - pc_jump = {pc_inc[31:28], jump_target, 2'b00}.
  - crs passed through unchanged.
  - All arithmetic is modulo 2^32; wrap-around (e.g. pc=32'hFFFF_FFFC, inc gives 0) is silent.
- FSM states: FETCH, ISSUE.
  - FETCH:
    - imem_req=1, imem_addr=pc; counter increments each cycle without ack.
    - On imem_ack: instr<=imem_rdata, instr_valid<=1, counter<=0, go to ISSUE, imem_req drops next cycle.
    - On counter reaching TIMEOUT_CYCLES-1 with no ack: fetch_err pulses for 1 cycle, counter<=0, stay in FETCH.
    - imem_req stays high across a timeout; the same address is re-requested.
    - An ack arriving in the same cycle as the timeout wins; no fetch_err is raised.
  - ISSUE:
    - instr_valid=1, instr held stable.
    - On instr_ready: pc<=selected candidate, instr_valid<=0, go to FETCH.
    - Without instr_ready: everything holds, no PC change.
- Latency: minimum 2 cycles per instruction (ack in first FETCH cycle, ready in first ISSUE cycle).
- pc changes only on the ISSUE->FETCH transition; next_pc_sel is ignored at all other times.
- imem_ack outside FETCH is ignored.
- rst asserted mid-fetch or mid-issue aborts the operation immediately; all outputs return to their reset values.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - On instr_ready with a selected target whose bits [1:0] != 0 (only possible with crs):
    - misalign pulses 1 cycle.
    - pc<=RESET_PC instead of the target.
- Not defined:
  - No misalign port.
  - crs is loaded unmodified, including its low bits.

Test Plan:
- Reset with RESET_PC=0 -> pc=0, instr_valid=0; imem_req=1 with imem_addr=0 on the first edge after rst drops.
- Fetch 32'h2001_0005 with ack in the first cycle, ready asserted one cycle later with sel=00 -> instr_valid for exactly 1 cycle, pc=4, then imem_addr=4.
- pc=32'h10, sel=01, branch_imm=16'hFFFE -> pc=32'h0C; sel=10, jump_target=26'h000_0040, pc=32'h1000_0000 -> pc=32'h1000_0100.
- Withhold ack for TIMEOUT_CYCLES=16 -> fetch_err pulse in cycle 16, imem_req stays high; ack in cycle 20 -> normal issue.
- pc=32'hFFFF_FFFC, sel=00 -> pc wraps to 0; assert rst while in ISSUE -> instr_valid=0 immediately, pc=RESET_PC.
- PC_ALIGN_CHECK_EN defined, sel=11, crs=32'h0000_0102 -> misalign pulse, pc=RESET_PC; undefined -> pc=32'h0000_0102.
